// File: rtl/rand_draw_arbiter.sv
// Round-robin arbiter handing out unbiased digits 0..m-1 (Lemire multiply-shift with rejection) from a shared 10-bit random word.
// Latency: grant at edge T, first sample at T+1, ack pulse in the following cycle, next arbitration at T+3.
// Backpressure: one draw in flight; other requesters hold req until acked. Optional stats: RAND_DRAW_STATS_EN.
module rand_draw_arbiter #(
   parameter int N_REQ   = 4,
   parameter int MAX_TRY = 15
) (
   input  logic               qzt_clk,
   input  logic               reset_n,
   input  logic [9:0]         rand_in,
   input  logic [N_REQ-1:0]   req,
   input  logic [4*N_REQ-1:0] mod_in,
   output logic [N_REQ-1:0]   ack,
   output logic [3:0]         rand_out,
   output logic               err,
   output logic               busy
`ifdef RAND_DRAW_STATS_EN
   ,
   output logic [15:0]        rej_cnt,
   output logic [7:0]         forced_cnt
`endif
);

   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int SW    = ID_W + 1;
   localparam int TRY_W = ($clog2(MAX_TRY + 1) > 0) ? $clog2(MAX_TRY + 1) : 1;

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   gnt_id;
   logic [ID_W-1:0]   pick_id;
   logic              pick_vld;
   logic [3:0]        pick_m;
   logic              pick_legal;
   logic [3:0]        m_q;
   logic [TRY_W-1:0]  try_cnt;
   logic [3:0]        mods [N_REQ];
   logic [13:0]       prod;
   logic [3:0]        cand;
   logic [9:0]        low;
   logic [9:0]        thr;
   logic              accept;
   logic              forced;

   // 1024 mod m: low products below this fall in the biased tail and are rejected
   function automatic logic [9:0] thr_of(input logic [3:0] m);
      case (m)
         4'd3:                thr_of = 10'd1;
         4'd5, 4'd6, 4'd10:   thr_of = 10'd4;
         4'd7:                thr_of = 10'd2;
         4'd9:                thr_of = 10'd7;
         default:             thr_of = 10'd0;
      endcase
   endfunction

   // (base + off) wrapped into 0..N_REQ-1, off is always below N_REQ
   function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
      logic [ID_W:0] s;
      s = {1'b0, base} + SW'(off);
      if (s >= SW'(N_REQ)) s = s - SW'(N_REQ);
      return s[ID_W-1:0];
   endfunction

   for (genvar i = 0; i < N_REQ; i++) begin : g_mod
      assign mods[i] = mod_in[4*i +: 4];
   end

   // first requester at or after rr_ptr; scanning downwards so the nearest one wins
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[rr_idx(rr_ptr, k)]) begin
            pick_vld = 1'b1;
            pick_id  = rr_idx(rr_ptr, k);
         end
      end
   end

   assign pick_m     = mods[pick_id];
   assign pick_legal = (pick_m >= 4'd2) && (pick_m <= 4'd10);

   // Lemire sample: high nibble is the candidate digit, low bits decide acceptance
   assign prod   = {4'b0, rand_in} * {10'b0, m_q};
   assign cand   = prod[13:10];
   assign low    = prod[9:0];
   assign thr    = thr_of(m_q);
   assign accept = (low >= thr);
   assign forced = !accept && (try_cnt == TRY_W'(MAX_TRY));

   assign busy = (state != IDLE);

   // state register
   always_ff @(posedge qzt_clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // next state: illegal moduli skip straight to the ack cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (pick_vld) state_nxt = pick_legal ? DRAW : DONE;
         DRAW: if (accept || forced) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // grant latch, retry counter, result registers and the ack pulse
   always_ff @(posedge qzt_clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr   <= '0;
         gnt_id   <= '0;
         m_q      <= '0;
         try_cnt  <= '0;
         ack      <= '0;
         rand_out <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ack <= '0;
               if (pick_vld) begin
                  gnt_id  <= pick_id;
                  m_q     <= pick_m;
                  try_cnt <= '0;
                  if (!pick_legal) begin
                     rand_out <= '0;
                     err      <= 1'b1;
                     ack      <= N_REQ'(1) << pick_id;
                  end
               end
            end
            DRAW: begin
               if (accept || forced) begin
                  rand_out <= cand;
                  err      <= forced;
                  ack      <= N_REQ'(1) << gnt_id;
               end else begin
                  try_cnt <= try_cnt + TRY_W'(1);
               end
            end
            DONE: begin
               ack    <= '0;
               rr_ptr <= rr_idx(gnt_id, 1);
            end
            default: ack <= '0;
         endcase
      end
   end

`ifdef RAND_DRAW_STATS_EN
   // saturating counts of rejected samples and of forced deliveries
   always_ff @(posedge qzt_clk or negedge reset_n) begin
      if (!reset_n) begin
         rej_cnt    <= '0;
         forced_cnt <= '0;
      end else if (state == DRAW && !accept) begin
         if (rej_cnt != '1)              rej_cnt    <= rej_cnt + 16'd1;
         if (forced && forced_cnt != '1) forced_cnt <= forced_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rand_draw_arbiter.sv
// Directed bench for rand_draw_arbiter with hand-computed expected digits and cycle counts.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: requesters drop req right after their ack, as the block requires.
module tb_rand_draw_arbiter;

   logic        qzt_clk;
   logic        reset_n;
   logic [9:0]  rand_in;
   logic [3:0]  req;
   logic [15:0] mod_in;
   logic [3:0]  ack;
   logic [3:0]  rand_out;
   logic        err;
   logic        busy;
`ifdef RAND_DRAW_STATS_EN
   logic [15:0] rej_cnt;
   logic [7:0]  forced_cnt;
`endif

   int n_chk;
   int n_fail;

   rand_draw_arbiter #(.N_REQ(4), .MAX_TRY(15)) dut (
      .qzt_clk  (qzt_clk),
      .reset_n  (reset_n),
      .rand_in  (rand_in),
      .req      (req),
      .mod_in   (mod_in),
      .ack      (ack),
      .rand_out (rand_out),
      .err      (err),
      .busy     (busy)
`ifdef RAND_DRAW_STATS_EN
      ,
      .rej_cnt    (rej_cnt),
      .forced_cnt (forced_cnt)
`endif
   );

   initial qzt_clk = 1'b0;
   always #5 qzt_clk = ~qzt_clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge qzt_clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   // counts edges until ack rises, bounded by limit
   task automatic wait_ack(input string tag, input int limit, output int cyc);
      cyc = 0;
      while (ack == 4'b0 && cyc < limit) begin
         tick();
         cyc++;
      end
      check({tag, "_ack_seen"}, int'(ack != 4'b0), 1);
   endtask

   initial begin
      int cyc;
      int hist [8];
      int bad;
      logic [3:0] exp_seq [5];
      logic [3:0] seen;

      n_chk   = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      req     = 4'b0;
      rand_in = 10'd0;
      mod_in  = 16'h0000;
      #1;

      // reset state
      check("rst_ack", int'(ack), 0);
      check("rst_rand_out", int'(rand_out), 0);
      check("rst_err", int'(err), 0);
      check("rst_busy", int'(busy), 0);
`ifdef RAND_DRAW_STATS_EN
      check("rst_rej_cnt", int'(rej_cnt), 0);
      check("rst_forced_cnt", int'(forced_cnt), 0);
`endif
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      check("idle_busy", int'(busy), 0);

      // basic accept: 515*10 = 5150 -> digit 5, low 30
      mod_in[3:0] = 4'd10;
      rand_in     = 10'd515;
      req         = 4'b0001;
      tick();
      check("basic_busy_draw", int'(busy), 1);
      check("basic_no_early_ack", int'(ack), 0);
      wait_ack("basic", 6, cyc);
      check("basic_cyc", cyc, 1);
      check("basic_ack", int'(ack), 1);
      check("basic_rand_out", int'(rand_out), 5);
      check("basic_err", int'(err), 0);
      check("basic_busy_done", int'(busy), 1);
      req = 4'b0;
      tick();
      check("basic_ack_low", int'(ack), 0);
      check("basic_busy_idle", int'(busy), 0);
      check("basic_hold", int'(rand_out), 5);

      // reject three times with rand 0, then 1023*10 = 10230 -> digit 9
      rand_in = 10'd0;
      req     = 4'b0001;
      for (int i = 0; i < 4; i++) tick();
      check("rej_no_ack", int'(ack), 0);
      check("rej_busy", int'(busy), 1);
      rand_in = 10'd1023;
      wait_ack("rej", 4, cyc);
      check("rej_cyc", cyc, 1);
      check("rej_rand_out", int'(rand_out), 9);
      check("rej_err", int'(err), 0);
`ifdef RAND_DRAW_STATS_EN
      check("rej_rej_cnt", int'(rej_cnt), 3);
`endif
      req = 4'b0;
      tick();

      // forced delivery: m=9 with rand 0 never passes threshold 7
      do_reset();
      mod_in[3:0] = 4'd9;
      rand_in     = 10'd0;
      req         = 4'b0001;
      wait_ack("forced", 40, cyc);
      check("forced_cyc", cyc, 17);
      check("forced_rand_out", int'(rand_out), 0);
      check("forced_err", int'(err), 1);
`ifdef RAND_DRAW_STATS_EN
      check("forced_rej_cnt", int'(rej_cnt), 16);
      check("forced_forced_cnt", int'(forced_cnt), 1);
`endif
      req = 4'b0;
      tick();

      // power of two: 1023*8 >> 10 = 7, never rejected
      mod_in[3:0] = 4'd8;
      rand_in     = 10'd1023;
      req         = 4'b0001;
      wait_ack("pow2", 6, cyc);
      check("pow2_cyc", cyc, 2);
      check("pow2_rand_out", int'(rand_out), 7);
      check("pow2_err", int'(err), 0);
      req = 4'b0;
      tick();

      foreach (hist[i]) hist[i] = 0;
      bad = 0;
      for (int v = 0; v < 1024; v++) begin
         rand_in = v[9:0];
         req     = 4'b0001;
         wait_ack("sweep", 6, cyc);
         hist[rand_out[2:0]]++;
         if (cyc != 2 || err || rand_out > 4'd7) bad++;
         req = 4'b0;
         tick();
      end
      for (int d = 0; d < 8; d++) check($sformatf("sweep_hist_%0d", d), hist[d], 128);
      check("sweep_rejects", bad, 0);
`ifdef RAND_DRAW_STATS_EN
      check("sweep_rej_cnt", int'(rej_cnt), 16);
`endif

      // round robin: 600*5 = 3000 -> digit 2; req0 re-raised after its ack
      do_reset();
      mod_in  = 16'h5555;
      rand_in = 10'd600;
      req     = 4'b1111;
      exp_seq[0] = 4'b0001;
      exp_seq[1] = 4'b0010;
      exp_seq[2] = 4'b0100;
      exp_seq[3] = 4'b1000;
      exp_seq[4] = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         wait_ack($sformatf("rr%0d", k), 6, cyc);
         check($sformatf("rr%0d_ack", k), int'(ack), int'(exp_seq[k]));
         check($sformatf("rr%0d_cyc", k), cyc, 2);
         check($sformatf("rr%0d_rand_out", k), int'(rand_out), 2);
         req = req & ~ack;
         tick();
         if (k == 0) req[0] = 1'b1;
      end

      // illegal moduli: m3=11 then m2=0
      mod_in[15:12] = 4'd11;
      req           = 4'b1000;
      wait_ack("ill3", 6, cyc);
      check("ill3_cyc", cyc, 1);
      check("ill3_ack", int'(ack), 8);
      check("ill3_rand_out", int'(rand_out), 0);
      check("ill3_err", int'(err), 1);
      req = 4'b0;
      tick();
      mod_in[11:8] = 4'd0;
      req          = 4'b0100;
      wait_ack("ill2", 6, cyc);
      check("ill2_cyc", cyc, 1);
      check("ill2_ack", int'(ack), 4);
      check("ill2_rand_out", int'(rand_out), 0);
      check("ill2_err", int'(err), 1);
      req = 4'b0;
      tick();

      // reset in the middle of a draw for requester 2 (rr_ptr is 3 here)
      mod_in[11:8] = 4'd9;
      rand_in      = 10'd0;
      req          = 4'b0100;
      tick();
      tick();
      tick();
      check("mid_busy_before", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_ack", int'(ack), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_err", int'(err), 0);
      check("mid_rst_rand_out", int'(rand_out), 0);
`ifdef RAND_DRAW_STATS_EN
      check("mid_rst_rej_cnt", int'(rej_cnt), 0);
`endif
      req = 4'b0;
      tick();
      reset_n = 1'b1;
      seen = 4'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         seen = seen | ack;
      end
      check("mid_no_ack", int'(seen), 0);

      // 1000*3 = 3000 -> digit 2; first grant must go to requester 0
      mod_in  = 16'h3333;
      rand_in = 10'd1000;
      req     = 4'b1111;
      wait_ack("post_rst", 6, cyc);
      check("post_rst_ack", int'(ack), 1);
      check("post_rst_rand_out", int'(rand_out), 2);
      req = 4'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rand_draw_arbiter.md
Name: rand_draw_arbiter

Overview:
- Shares one free-running 10-bit random word among N_REQ requesters; each requester asks for one uniform integer in 0..m-1, with m from 2 to 10.
- Arbitration is round-robin; one draw is in flight at a time.
- Uses exact Lemire multiply-shift with rejection, so there is no bias from the 1024-state source.
- Sits between the random generator / bit-mixing stage and the game/display logic that consumes digits.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_TRY, 15, rejected samples allowed per draw before a forced (flagged) delivery.

Ports:
- qzt_clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rand_in  in  10  random word, new value every cycle, sampled every clock.
- req  in  N_REQ  per-requester request level; held high until ack.
- mod_in  in  4*N_REQ  modulus m per requester; requester i uses bits [4i+3:4i]; must be stable while req[i] is high.
- ack  out  N_REQ  one-hot, one-cycle pulse to the served requester.
- rand_out  out  4  drawn value; valid from the ack cycle, held until the next ack.
- err  out  1  qualifies rand_out in the ack cycle; held with rand_out.
- busy  out  1  high in DRAW and DONE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; ack=0, rand_out=0, err=0, busy=0.
  - rr_ptr=0, try_cnt=0, latched id/m = 0.
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - If req != 0, pick the first set bit at or after rr_ptr, cyclic and wrapping N_REQ-1 to 0.
  - Latch gnt_id and m = mod_in[gnt_id]; clear try_cnt; go DRAW.
  - Otherwise stay in IDLE.
- Illegal m (0, 1, or >10), detected at latch:
  - Skip DRAW; go to DONE with rand_out=0, err=1, ack[gnt_id]=1.
- DRAW, each cycle:
  - p = rand_in*m (14 bits); cand = p[13:10]; low = p[9:0].
  - thr = 1024 mod m, from a constant table:
    - m = 2, 4, 8: thr 0
    - m = 3: thr 1
    - m = 5, 6, 10: thr 4
    - m = 7: thr 2
    - m = 9: thr 7
  - Accept if low >= thr: rand_out<=cand, err<=0, ack[gnt_id]<=1, go DONE.
  - Reject if low < thr: try_cnt++, stay in DRAW.
  - If a sample is rejected with try_cnt==MAX_TRY: deliver cand anyway with err=1, go DONE.
- DONE:
  - Lasts exactly one cycle; the ack bit is low again when leaving DONE.
  - Set rr_ptr = (gnt_id+1) mod N_REQ; go IDLE unconditionally.
- Latency and requester rules:
  - req seen at edge T leads to DRAW at T; the first acceptable sample is at edge T+1.
  - ack is high for the cycle after T+1; the next arbitration happens at edge T+3.
  - The served requester must drop req before edge T+3, otherwise it is a new request.
- req deasserted by the granted requester during DRAW: the draw still completes and the ack still pulses (no abort).
- Simultaneous requests: strict round-robin, so no requester waits more than N_REQ-1 draws.
- Reset mid-draw: drop the transaction silently; no ack is ever issued for it.

Optional Feature:
- Macro: RAND_DRAW_STATS_EN.
- Defined:
  - Adds output rej_cnt (16 bits), a saturating count of rejected samples.
  - Adds output forced_cnt (8 bits), a saturating count of MAX_TRY forced deliveries.
  - Both counters reset to 0 and hold at all-ones.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Basic accept:
  - req=0001, m0=10, rand_in=515 (p=5150, low=30>=4).
  - Expect ack=0001 two cycles after req, rand_out=5, err=0, busy high for 2 cycles.
- Reject then accept:
  - m0=10, rand_in=0 for 3 cycles then 1023.
  - Expect 3 rejections, then rand_out=9, err=0; ack on the 4th DRAW cycle.
- Forced delivery:
  - m0=9, rand_in held at 0.
  - Expect ack after 16 DRAW cycles with rand_out=0, err=1; forced_cnt=1 and rej_cnt=16 when RAND_DRAW_STATS_EN is defined.
- Power of two:
  - m=8, rand_in=1023.
  - Expect rand_out=7 on the first try.
  - Sweep rand_in 0..1023: each value 0..7 occurs 128 times, with no rejects.
- Round-robin:
  - req=1111 held, each requester dropping req after its own ack.
  - Expect acks in order 0001, 0010, 0100, 1000.
  - Re-raising req0 right after its ack does not pre-empt 1, 2, 3.
- Illegal m and reset:
  - m2=0 gives ack[2] with rand_out=0, err=1.
  - reset_n pulsed low during DRAW: all outputs go to 0 immediately; no ack follows; rr_ptr=0.
